// File: rtl/fetch_exc_pipe_pkg.sv
// Shared decode constants, exception codes and FSM encoding for the fetch
// exception pipe and any D-stage logic that reuses the branch decoder.
package fetch_exc_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] EXC_NONE   = 5'd0;
  localparam logic [4:0] EXC_ADEL   = 5'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_e;

  function automatic logic addr_fault(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_exc_pipe_branch_dec.sv
// Combinational branch/jump detector; flags instructions that own a delay slot.
module branch_dec
  import fetch_exc_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_branch
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    is_branch = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_REGIMM, OP_BGTZ, OP_BLEZ, OP_J, OP_JAL:
        is_branch = 1'b1;
      OP_SPECIAL:
        is_branch = (funct == FN_JR) || (funct == FN_JALR);
      default:
        is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_exc_pipe.sv
// F/D pipeline register with fetch address-error detection, delay-slot tagging
// and a RUN/PEND squash FSM that holds the pipe off until CP0 redirects.
//
// state   | meaning
// RUN     | fetches flow normally into D
// PEND    | a fetch fault sits in D; later fetches are squashed until flush
module fetch_exc_pipe
  import fetch_exc_pipe_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] TEXT_LO = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] TEXT_HI = ADDR_W'(32'h0000_4ffc),
  parameter int                EXC_W   = 5,
  parameter int                CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic              valid_f,
  input  logic [31:0]       instr_d,
  input  logic              valid_d_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [ADDR_W-1:0] pc_d,
  output logic              valid_d,
  output logic [EXC_W-1:0]  exccode_d,
  output logic              bd_d,
  output logic              kill_f,
  output logic [CNT_W-1:0]  exc_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fd_pc_q, fd_pc_d;
  logic              fd_valid_q, fd_valid_d;
  logic [EXC_W-1:0]  fd_exc_q, fd_exc_d;
  logic              fd_bd_q, fd_bd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic d_is_branch;
  logic fault;
  logic advance;
  logic fetch_live;
  logic capture;

  branch_dec u_branch_dec (
    .instr     (instr_d),
    .is_branch (d_is_branch)
  );

  assign kill_f     = (state_q == ST_PEND);
  assign fault      = valid_f && ((pc_f[1:0] != 2'b00) || (pc_f < TEXT_LO) || (pc_f > TEXT_HI));
  assign advance    = !stall && !flush;
  assign fetch_live = valid_f && !kill_f;
  // only a live fetch that actually moves into D counts as a captured fault
  assign capture    = advance && fetch_live && fault;

  always_comb begin
    fd_pc_d    = fd_pc_q;
    fd_valid_d = fd_valid_q;
    fd_exc_d   = fd_exc_q;
    fd_bd_d    = fd_bd_q;
    if (flush) begin
      fd_valid_d = 1'b0;
      fd_exc_d   = '0;
      fd_bd_d    = 1'b0;
    end else if (advance) begin
      fd_pc_d    = pc_f;
      fd_valid_d = fetch_live;
      fd_exc_d   = (fetch_live && fault) ? EXC_W'(EXC_ADEL) : EXC_W'(EXC_NONE);
      fd_bd_d    = valid_d_in && d_is_branch && fetch_live;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (capture) state_d = ST_PEND;
      ST_PEND: if (flush)   state_d = ST_RUN;
      default:              state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = capture ? CNT_W'(1) : '0;
    end else if (capture && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fd_pc_q    <= TEXT_LO;
      fd_valid_q <= 1'b0;
      fd_exc_q   <= '0;
      fd_bd_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fd_pc_q    <= fd_pc_d;
      fd_valid_q <= fd_valid_d;
      fd_exc_q   <= fd_exc_d;
      fd_bd_q    <= fd_bd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_d      = fd_pc_q;
  assign valid_d   = fd_valid_q;
  assign exccode_d = fd_exc_q;
  assign bd_d      = fd_bd_q;
  assign exc_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_exc_pipe.sv
// Directed plus randomized bench for fetch_exc_pipe, checked against a
// cycle-level behavioural model of the F/D register and fault bookkeeping.
module tb_fetch_exc_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        valid_f;
  logic [31:0] instr_d;
  logic        valid_d_in;
  logic        stall;
  logic        flush;
  logic        cnt_clr;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [4:0]  exccode_d;
  logic        bd_d;
  logic        kill_f;
  logic [7:0]  exc_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // behavioural model state
  logic [31:0] m_pc;
  bit          m_valid;
  int          m_exc;
  bit          m_bd;
  bit          m_pend;
  int          m_cnt;

  localparam logic [31:0] I_ADDU = 32'h0085_1821;
  localparam logic [31:0] I_BEQ  = 32'h1043_0005;
  localparam logic [31:0] I_JALR = 32'h0060_f809;

  bit [5:0] br_ops [7] = '{6'h04, 6'h05, 6'h01, 6'h07, 6'h06, 6'h02, 6'h03};

  fetch_exc_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .pc_f       (pc_f),
    .valid_f    (valid_f),
    .instr_d    (instr_d),
    .valid_d_in (valid_d_in),
    .stall      (stall),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .pc_d       (pc_d),
    .valid_d    (valid_d),
    .exccode_d  (exccode_d),
    .bd_d       (bd_d),
    .kill_f     (kill_f),
    .exc_cnt    (exc_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_branch(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    foreach (br_ops[i]) if (op == int'(br_ops[i])) return 1'b1;
    return (op == 0) && (fn == 8 || fn == 9);
  endfunction

  function automatic bit model_bad(input logic [31:0] pc);
    longint unsigned a = longint'(pc);
    return (a % 4 != 0) || (a < 64'h3000) || (a > 64'h4ffc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance the model by one clock from the current inputs, then compare
  task automatic step();
    bit live, bad, got;
    got = 1'b0;
    if (!reset) begin
      m_pc = 32'h3000; m_valid = 0; m_exc = 0; m_bd = 0; m_pend = 0; m_cnt = 0;
    end else begin
      live = valid_f && !m_pend;
      bad  = valid_f && model_bad(pc_f);
      if (flush) begin
        m_valid = 0; m_exc = 0; m_bd = 0; m_pend = 0;
      end else if (!stall) begin
        m_pc    = pc_f;
        m_valid = live;
        m_exc   = (live && bad) ? 4 : 0;
        m_bd    = valid_d_in && model_branch(instr_d) && live;
        if (live && bad) begin
          got    = 1'b1;
          m_pend = 1'b1;
        end
      end
      if (cnt_clr)                 m_cnt = got ? 1 : 0;
      else if (got && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    chk("pc_d",      pc_d,              m_pc);
    chk("valid_d",   32'(valid_d),      32'(m_valid));
    chk("exccode_d", 32'(exccode_d),    32'(m_exc));
    chk("bd_d",      32'(bd_d),         32'(m_bd));
    chk("kill_f",    32'(kill_f),       32'(m_pend));
    chk("exc_cnt",   32'(exc_cnt),      32'(m_cnt));
  endtask

  task automatic drive(input logic [31:0] pc, input bit vf, input logic [31:0] ins,
                       input bit vd, input bit st, input bit fl, input bit cc);
    pc_f = pc; valid_f = vf; instr_d = ins; valid_d_in = vd;
    stall = st; flush = fl; cnt_clr = cc;
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 7))
      0:       return 32'h3000 + ($urandom_range(0, 32'h7ff) << 2);
      1:       return 32'h3000 + ($urandom_range(0, 32'h7ff) << 2);
      2:       return 32'h3000 + $urandom_range(0, 32'h1fff);
      3:       return 32'h2ffc - ($urandom_range(0, 16) << 2);
      4:       return 32'h5000 + ($urandom_range(0, 16) << 2);
      5:       return ($urandom_range(0, 1) != 0) ? 32'h3000 : 32'h4ffc;
      6:       return $urandom;
      default: return 32'h3000 + ($urandom_range(0, 32'h7ff) << 2);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0:       return I_BEQ;
      1:       return I_JALR;
      2:       return {r[31:6], 6'h08} & 32'h03ff_ffff;
      3:       return {br_ops[$urandom_range(0, 6)], r[25:0]};
      4:       return I_ADDU;
      default: return r;
    endcase
  endfunction

  initial begin
    drive(32'h0, 1'b0, I_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk("reset_pc", pc_d, 32'h3000);
    reset = 1'b1;

    drive(32'h3000, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(32'h3004, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("seq_pc", pc_d, 32'h3004);

    drive(32'h3008, 1'b1, I_BEQ,  1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("bd_beq", 32'(bd_d), 32'd1);
    drive(32'h300c, 1'b1, I_JALR, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(32'h3010, 1'b1, I_BEQ,  1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("bd_bubble", 32'(bd_d), 32'd0);

    drive(32'h3002, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("misalign_exc", 32'(exccode_d), 32'd4);
    drive(32'h3008, 1'b1, I_BEQ,  1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("killed_valid", 32'(valid_d), 32'd0);
    drive(32'h3008, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("flush_cnt", 32'(exc_cnt), 32'd1);

    drive(32'h2ffc, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(32'h2ffc, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b1, 1'b0); step();
    drive(32'h5000, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(32'h5000, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b1, 1'b0); step();
    drive(32'h4ffc, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("hi_edge_exc", 32'(exccode_d), 32'd0);

    drive(32'h0000, 1'b1, I_BEQ,  1'b1, 1'b1, 1'b1, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      drive(32'h3100 + 32'(i * 4), 1'b1, I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0); step();
    end

    for (int i = 0; i < 256; i++) begin
      drive(32'h0001, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(32'h0001, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b1, 1'b0); step();
    end
    chk("sat_cnt", 32'(exc_cnt), 32'd255);
    drive(32'h6000, 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b1); step();
    chk("clr_inc_cnt", 32'(exc_cnt), 32'd1);
    drive(32'h6000, 1'b1, I_ADDU, 1'b1, 1'b1, 1'b0, 1'b0); step();
    reset = 1'b0;
    drive(32'h3004, 1'b1, I_BEQ, 1'b1, 1'b1, 1'b1, 1'b1); step();
    chk("reset_pend_kill", 32'(kill_f), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      drive(rand_pc(), ($urandom_range(0, 4) != 0), rand_instr(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
